// File: rtl/draw_score_pkg.sv
// Shared definitions for the on-screen overlay blocks.
//   vga_t          : VGA bus carried between the draw_* stages (VGA_BUS_SIZE bits)
//   DIGIT_*        : digit cell geometry, reusable by any text overlay
//   seg_map()      : digit -> {a,b,c,d,e,f,g} segment enables
//   cell_select()  : locates a pixel inside a two-digit score field
package draw_score_pkg;

    // VGA bus layout; fields are accessed by name through this struct.
    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam int VGA_BUS_SIZE = $bits(vga_t);

    // Digit geometry in pixels.
    localparam int DIGIT_W     = 24;
    localparam int DIGIT_H     = 40;
    localparam int SEG_T       = 4;
    localparam int DIGIT_PITCH = 32;

    // Digit code that lights no segment (suppressed leading zero).
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef struct packed {
        logic       hit;
        logic [4:0] col;
        logic [5:0] row;
        logic [3:0] digit;
    } cell_t;

    function automatic logic [6:0] seg_map(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    // Offsets are unsigned, so a pixel left of / above the field wraps to a
    // large value and simply fails the range compare.
    function automatic cell_t cell_select(input logic [10:0] hcount,
                                          input logic [10:0] vcount,
                                          input logic [10:0] xpos,
                                          input logic [10:0] ypos,
                                          input logic [3:0]  score,
                                          input logic        visible);
        cell_t       c;
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] dx_units;
        logic        has_tens;
        logic [3:0]  units;
        c        = '0;
        c.digit  = DIGIT_BLANK;
        dx       = hcount - xpos;
        dy       = vcount - ypos;
        dx_units = dx - 11'(DIGIT_PITCH);
        has_tens = (score >= 4'd10);
        units    = has_tens ? score - 4'd10 : score;
        if (visible && dy < 11'(DIGIT_H)) begin
            c.row = dy[5:0];
            if (dx < 11'(DIGIT_W)) begin
                c.hit   = has_tens;
                c.col   = dx[4:0];
                c.digit = has_tens ? 4'd1 : DIGIT_BLANK;
            end else if (dx_units < 11'(DIGIT_W)) begin
                c.hit   = 1'b1;
                c.col   = dx_units[4:0];
                c.digit = units;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/draw_score_seven_seg.sv
// seven_seg_pixel: decides whether a cell-relative pixel falls on a lit
// segment of the given digit.
//   digit_i : 0..9, anything else draws nothing
//   col_i   : column inside the cell, 0..DIGIT_W-1
//   row_i   : row inside the cell, 0..DIGIT_H-1
//   lit_o   : pixel belongs to a lit segment
module seven_seg_pixel
    import draw_score_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic [4:0] col_i,
    input  logic [5:0] row_i,
    output logic       lit_o
);
    logic [6:0] segs;
    logic       top, mid, bot, left, right, upper;

    assign segs  = seg_map(digit_i);
    assign top   = row_i < 6'(SEG_T);
    assign mid   = (row_i >= 6'(DIGIT_H/2 - SEG_T/2)) && (row_i < 6'(DIGIT_H/2 + SEG_T/2));
    assign bot   = row_i >= 6'(DIGIT_H - SEG_T);
    assign left  = col_i < 5'(SEG_T);
    assign right = col_i >= 5'(DIGIT_W - SEG_T);
    assign upper = row_i < 6'(DIGIT_H/2);

    // segs = {a,b,c,d,e,f,g}
    assign lit_o = (segs[6] & top)
                 | (segs[5] & right & upper)
                 | (segs[4] & right & ~upper)
                 | (segs[3] & bot)
                 | (segs[2] & left & ~upper)
                 | (segs[1] & left & upper)
                 | (segs[0] & mid);

endmodule

// File: rtl/draw_score.sv
// draw_score: overlays both players' scores as 7-segment digits on the VGA
// bus, two pclk cycles of latency on every field.
//   pclk_i          : pixel clock
//   rst_ni          : asynchronous active-low reset
//   vga_in_i        : bus from draw_ball
//   score_player*_i : scores 0..15, latched on vsync rise
//   endgame_i       : match-over flag, latched on vsync rise
//   vga_out_o       : bus with the score overlay
module draw_score
    import draw_score_pkg::*;
#(
    parameter logic [10:0] XPOS_P1 = 11'd64,
    parameter logic [10:0] XPOS_P2 = 11'd896,
    parameter logic [10:0] YPOS    = 11'd32,
    parameter logic [11:0] COLOR   = 12'hFF0
) (
    input  logic                    pclk_i,
    input  logic                    rst_ni,
    input  logic [VGA_BUS_SIZE-1:0] vga_in_i,
    input  logic [3:0]              score_player1_i,
    input  logic [3:0]              score_player2_i,
    input  logic                    endgame_i,
    output logic [VGA_BUS_SIZE-1:0] vga_out_o
);
    vga_t       vin;
    logic       vsync_prev_q;
    logic       vsync_rise;
    logic [3:0] score1_q, score2_q;
    logic       endgame_q;
    logic [5:0] frame_q;
    logic       vis1, vis2;
    cell_t      cell1_d, cell2_d, cell1_q, cell2_q;
    vga_t       bus1_q, out_d, out_q;
    logic       lit1, lit2;

    assign vin        = vga_t'(vga_in_i);
    assign vsync_rise = vin.vsync & ~vsync_prev_q;

    // Winner blinks at frame-counter bit 5; a tie makes both sides winners.
    assign vis1 = ~(endgame_q & (score1_q >= score2_q) & frame_q[5]);
    assign vis2 = ~(endgame_q & (score2_q >= score1_q) & frame_q[5]);

    always_comb begin
        cell1_d = cell_select(vin.hcount, vin.vcount, XPOS_P1, YPOS, score1_q, vis1);
        cell2_d = cell_select(vin.hcount, vin.vcount, XPOS_P2, YPOS, score2_q, vis2);
    end

    seven_seg_pixel u_seg_p1 (
        .digit_i (cell1_q.digit),
        .col_i   (cell1_q.col),
        .row_i   (cell1_q.row),
        .lit_o   (lit1)
    );

    seven_seg_pixel u_seg_p2 (
        .digit_i (cell2_q.digit),
        .col_i   (cell2_q.col),
        .row_i   (cell2_q.row),
        .lit_o   (lit2)
    );

    always_comb begin
        out_d = bus1_q;
        if (((cell1_q.hit & lit1) | (cell2_q.hit & lit2)) && !bus1_q.hblnk && !bus1_q.vblnk) begin
            out_d.rgb = COLOR;
        end
    end

    always_ff @(posedge pclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_prev_q <= 1'b0;
            score1_q     <= '0;
            score2_q     <= '0;
            endgame_q    <= 1'b0;
            frame_q      <= '0;
            bus1_q       <= '0;
            cell1_q      <= '0;
            cell2_q      <= '0;
            out_q        <= '0;
        end else begin
            vsync_prev_q <= vin.vsync;
            if (vsync_rise) begin
                score1_q  <= score_player1_i;
                score2_q  <= score_player2_i;
                endgame_q <= endgame_i;
                frame_q   <= frame_q + 6'd1;
            end
            bus1_q  <= vin;
            cell1_q <= cell1_d;
            cell2_q <= cell2_d;
            out_q   <= out_d;
        end
    end

    assign vga_out_o = out_q;

endmodule

// File: doc/draw_score.md
DRAW_SCORE -- requirements
Module: draw_score

Interface
REQ-001 XPOS_P1, 64: left pixel column of the player-1 tens digit cell.
REQ-002 XPOS_P2, 896: left pixel column of the player-2 tens digit cell.
REQ-003 YPOS, 32: top pixel row of all digit cells.
REQ-004 COLOR, 12'hFF0: 12-bit RGB applied to lit segment pixels.
REQ-005 pclk  input  1  pixel clock, 65 MHz, 1024x768 timing; the only clock.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 vga_in  input  VGA_BUS_SIZE  bus from draw_ball; fields addressed with the shared VGA field macros.
REQ-008 score_player1  input  4  player-1 score from judge, binary 0..15.
REQ-009 score_player2  input  4  player-2 score from judge, binary 0..15.
REQ-010 endgame  input  1  level from judge; high while the match is over.
REQ-011 vga_out  output  VGA_BUS_SIZE  bus with the score overlay; drives the top-level vs/hs/r/g/b.

Function
REQ-012 Latency: every vga_out field SHALL equal the vga_in field delayed by exactly 2 pclk cycles (hcount, vcount, syncs, blanks, rgb).
REQ-013 Score latch: both scores and endgame SHALL be sampled only on the cycle vsync_in rises; mid-frame changes SHALL NOT appear until the next frame.
REQ-014 Each latched score SHALL be converted to BCD tens (0..1) and units (0..9); a tens digit of 0 SHALL be blank (leading-zero suppression).
REQ-015 Digit cell: 24 wide x 40 high; tens cell at X, units cell at X+32, rows YPOS..YPOS+39.
REQ-016 Segments, cell-relative (col, row), thickness 4: a = rows 0-3, all cols; g = rows 18-21, all cols; d = rows 36-39, all cols; f = cols 0-3, rows 0-19; b = cols 20-23, rows 0-19; e = cols 0-3, rows 20-39; c = cols 20-23, rows 20-39.
REQ-017 Digit-to-segment map SHALL be standard 7-segment (0 = abcdef, 1 = bc, ..., 9 = abcdfg).
REQ-018 Stage 1 SHALL register the bus, cell hit, cell-relative coordinates and the selected digit. Stage 2 SHALL register the bus with rgb replaced by COLOR on a lit segment, otherwise passed through.
REQ-019 Overlay SHALL be suppressed (rgb passed through) whenever hblnk or vblnk of the same pipelined sample is high.
REQ-020 Frame counter: 6-bit, increments on each vsync_in rising edge and wraps 63->0.
REQ-021 Blink: while latched endgame = 1, the winner's digits SHALL be drawn only when frame counter bit 5 = 0. Winner = higher latched score; on equal scores both sides blink. While endgame = 0, no blinking.
REQ-022 A vsync rise coinciding with a score change SHALL latch the value present on that cycle.

Reset
REQ-023 While rst = 0: vga_out all fields 0, latched scores 0, latched endgame 0, frame counter 0, pipeline registers 0.
REQ-024 Reset asserted mid-frame SHALL clear the state immediately (asynchronously). After release, output SHALL resume 2 cycles after valid input, showing score "0" until the first vsync rise.

Structure
REQ-025 Digit geometry (cell size, thickness, digit pitch) SHALL live as constants in a shared header next to the VGA macros, reused by any future text overlay.
REQ-026 One combinational sub-module, seven_seg_pixel (inputs: digit, cell-relative col/row; output: lit), SHALL be instantiated once per side.
REQ-027 draw_score SHALL be inserted between draw_ball and the top-level outputs (bus index 4).

Verification
REQ-028 Scores 7/12, endgame 0, one full frame -> pixel (66,33) lit (P1 units? no: P1 tens blank) so (64..87,32..71) unlit; P1 units "7" segment a at (96..119,32..35) lit; P2 "1" at cols 916..919 and "2" segment g at (928..951,50..53) lit.
REQ-029 Score_player1 changed 3->4 at line 400 -> frame rendered with "3"; next frame after vsync rise renders "4".
REQ-030 Random bus stimulus outside the digit cells -> vga_out equals vga_in delayed by exactly 2 cycles on every field.
REQ-031 endgame = 1, scores 15/9 -> P1 digits are visible for frames with counter 0..31 and absent for 32..63; P2 digits are always visible.
REQ-032 Equal scores 5/5 with endgame = 1 -> both sides blink in phase. Pixel inside a cell during hblnk -> rgb passed through.
REQ-033 rst pulsed low at line 300 with scores 8/8 -> vga_out = 0 during reset; after release, "0" is shown on both sides until the next vsync rise, then "8".
